hdd_sector_server: RTL and testbench
====================================

# hdd_sector_server

Host-side responder for the ProDOS HDD card's sector interface. It picks up `hdd_read`/`hdd_write` pulses and the 16-bit `sector` number from the card, then runs a 512-byte block transfer with the MiSTer-style SD block host. During the transfer it drives the card's sector-buffer port (`ram_addr`/`ram_di`/`ram_we`, `ram_do`). It also tracks image mount state and publishes `hdd_mounted`/`hdd_protect` back to the card.

## Interface
Parameters:
- `LBA_BASE`, 0: added to `sector` to form `sd_lba`; selects the partition offset within the image.
- `TIMEOUT_CYCLES`, 14318180: watchdog limit in `CLK_14M` cycles (about 1 s); used only with `HDD_SERVER_TIMEOUT_EN`.

Ports:
- `CLK_14M`  in  1  system clock. One clock domain; all logic is in it.
- `RESET`  in  1  reset, asynchronous, active-high.
- `hdd_read`  in  1  one-cycle read request from the card.
- `hdd_write`  in  1  one-cycle write request from the card.
- `sector`  in  16  block number; sampled in the cycle the request is seen.
- `ram_addr`  out  9  sector-buffer address.
- `ram_di`  out  8  sector-buffer write data.
- `ram_we`  out  1  sector-buffer write enable.
- `ram_do`  in  8  sector-buffer read data; registered, valid 1 cycle after `ram_addr`.
- `sd_lba`  out  32  block address to the host.
- `sd_rd`  out  1  block read request (host to buffer).
- `sd_wr`  out  1  block write request (buffer to host).
- `sd_ack`  in  1  host transfer-active strobe.
- `sd_buff_addr`  in  9  host byte index.
- `sd_buff_dout`  in  8  host data on reads.
- `sd_buff_wr`  in  1  host byte strobe on reads.
- `sd_buff_din`  out  8  data to host on writes.
- `img_mounted`  in  1  one-cycle mount-change pulse.
- `img_size`  in  64  image size in bytes.
- `img_readonly`  in  1  image is read-only.
- `hdd_mounted`  out  1  image present (to the card).
- `hdd_protect`  out  1  write protect (to the card).
- `busy`  out  1  a transfer is in progress.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States and transitions:
  - `IDLE`:
    - A request is accepted here, from the inputs or from the pending slot.
    - On accept, latch the direction and set `sd_lba = LBA_BASE + {16'h0, sector}` (32-bit add, wraps modulo 2^32).
    - Go to `REQ`.
  - `REQ`:
    - Hold `sd_rd` (read) or `sd_wr` (write) high.
    - On `sd_ack` = 1, drop the request and go to `XFER`.
  - `XFER`:
    - Read direction: `ram_addr = sd_buff_addr`, `ram_di = sd_buff_dout`, `ram_we = sd_buff_wr & sd_ack`.
    - Write direction: `ram_addr = sd_buff_addr`, `sd_buff_din = ram_do`, `ram_we = 0`.
    - On `sd_ack` falling, go to `DONE`.
  - `DONE`:
    - Lasts one cycle, then returns to `IDLE`.
- Outside read-`XFER`, `ram_we` = 0. `ram_addr`, `ram_di` and `sd_buff_din` are 0 outside `XFER`.
- `sd_ack` or `sd_buff_wr` seen while in `IDLE` is ignored.
- Pending slot (one deep):
  - A request that arrives while not in `IDLE` is stored together with its `sector`.
  - A later request overwrites it, so the last request wins.
  - `IDLE` serves the pending slot before returning to waiting.
- If `hdd_read` and `hdd_write` arrive in the same cycle, the write is taken and the read is dropped.
- A write request is dropped, with no host traffic, when `hdd_protect` = 1 or `hdd_mounted` = 0.
- A read request is dropped when `hdd_mounted` = 0.
- Mount tracking:
  - On `img_mounted`: `hdd_mounted <= (img_size != 0)` and `hdd_protect <= img_readonly & (img_size != 0)`.
  - A mount change during a transfer does not abort it.
- `busy` = 1 in `REQ`, `XFER` and `DONE`.

## Timing
- Reset values: all outputs 0, state `IDLE`, pending slot empty.
- `RESET` asserted mid-transfer returns to `IDLE` immediately; the host ack in progress is then ignored.
- Request seen at cycle n: `sd_lba` is valid and `sd_rd`/`sd_wr` rise at n+1.
- `sd_ack` rise seen at cycle m: `sd_rd`/`sd_wr` low at m+1.
- Read data: a `sd_buff_wr` beat reaches the buffer the same cycle (`ram_we` is combinational).
- Write data: `sd_buff_din` is valid 1 cycle after `sd_buff_addr`. The host samples with 1-cycle latency.
- `sd_ack` fall seen at cycle k: `DONE` at k+1, `busy` = 0 at k+2. A pending request issues `sd_rd`/`sd_wr` at k+3.

## Configuration
- `HDD_SERVER_TIMEOUT_EN` defined:
  - A counter runs in `REQ` and `XFER` and clears on each state entry.
  - Reaching `TIMEOUT_CYCLES` drops `sd_rd`/`sd_wr`, pulses `err` for 1 cycle and forces `IDLE`.
  - The pending slot is kept.
- `HDD_SERVER_TIMEOUT_EN` undefined: no counter, `err` is tied to 0, and the block waits indefinitely.

## Structure
- Shared package `hdd_pkg`:
  - State enum: `IDLE`, `REQ`, `XFER`, `DONE`.
  - `HDD_SECTOR_BYTES` = 512.
  - `HDD_ADDR_W` = 9.
- Optional sub-module `hdd_watchdog`: counter plus compare, instantiated only under the macro. The rest is a single module.

## Test plan
- Mounted (`img_size` = 0x200000), `hdd_read` with `sector` = 0x0012, `LBA_BASE` = 0 -> `sd_lba` = 0x12, `sd_rd` for 1+ cycles. Host acks and streams bytes 0..511 = index&0xFF -> `ram_we` 512 times with matching `ram_addr`/`ram_di`, `busy` falls 2 cycles after ack falls.
- Mounted and writable, preload buffer, `hdd_write` with `sector` = 5 -> `sd_wr`, `sd_buff_din` equals buffer[`sd_buff_addr`] 1 cycle later for all 512 addresses, `ram_we` stays 0.
- `img_readonly` = 1 at mount, `hdd_write` -> `hdd_protect` = 1, no `sd_wr`, `busy` stays 0.
- Requests during a read: `hdd_read`(7) then `hdd_read`(9) -> after the first completes, the next `sd_lba` = 9 (last request wins); `hdd_read` + `hdd_write` same cycle -> `sd_wr` only.
- `RESET` in mid-`XFER` -> all outputs 0 at once, later `sd_buff_wr` beats give no `ram_we`.
- With `HDD_SERVER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 100, host never acks -> `err` pulse at cycle 100 after `REQ` entry, `sd_rd` = 0, state `IDLE`.

Source files
------------

// File: rtl/hdd_pkg.sv
// Shared types and sizes for the ProDOS HDD sector server.
package hdd_pkg;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} hdd_state_t;

  localparam int unsigned HDD_SECTOR_BYTES = 512;
  localparam int unsigned HDD_ADDR_W       = $clog2(HDD_SECTOR_BYTES);
endpackage

// File: rtl/hdd_watchdog.sv
// Transfer watchdog: counts cycles in a state and flags the limit cycle.
// Exists only when HDD_SERVER_TIMEOUT_EN is defined.
`ifdef HDD_SERVER_TIMEOUT_EN
module hdd_watchdog #(
  parameter int unsigned LIMIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired_c
);
  logic [31:0] cnt;
  logic [31:0] cnt_eff;

  // restart marks the first cycle of a state, whose count is zero
  assign cnt_eff   = restart ? 32'd0 : cnt;
  assign expired_c = run && (cnt_eff == 32'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= 32'd0;
    else if (!run) cnt <= 32'd0;
    else           cnt <= cnt_eff + 32'd1;
  end
endmodule
`endif

// File: rtl/hdd_sector_server.sv
// Host-side sector server between the HDD card buffer and the SD block host.
// Optional watchdog abort enabled by defining HDD_SERVER_TIMEOUT_EN.
module hdd_sector_server
  import hdd_pkg::*;
#(
  parameter logic [31:0] LBA_BASE       = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 14318180
) (
  input  logic                  CLK_14M,
  input  logic                  RESET,
  input  logic                  hdd_read,
  input  logic                  hdd_write,
  input  logic [15:0]           sector,
  output logic [HDD_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_di,
  output logic                  ram_we,
  input  logic [7:0]            ram_do,
  output logic [31:0]           sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  input  logic [HDD_ADDR_W-1:0] sd_buff_addr,
  input  logic [7:0]            sd_buff_dout,
  input  logic                  sd_buff_wr,
  output logic [7:0]            sd_buff_din,
  input  logic                  img_mounted,
  input  logic [63:0]           img_size,
  input  logic                  img_readonly,
  output logic                  hdd_mounted,
  output logic                  hdd_protect,
  output logic                  busy,
  output logic                  err
);
  hdd_state_t  state;
  logic        dir_wr;
  logic        pend_valid;
  logic        pend_wr;
  logic [15:0] pend_sector;

  logic        in_req;
  logic        take;
  logic        sel_wr;
  logic        allowed;
  logic [15:0] sel_sector;

  // live request beats the pending slot; write beats read
  assign in_req     = hdd_read | hdd_write;
  assign take       = in_req | pend_valid;
  assign sel_wr     = in_req ? hdd_write : pend_wr;
  assign sel_sector = in_req ? sector : pend_sector;
  assign allowed    = sel_wr ? (hdd_mounted & ~hdd_protect) : hdd_mounted;

`ifdef HDD_SERVER_TIMEOUT_EN
  logic wd_restart;
  logic wd_expired;

  hdd_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (CLK_14M),
    .rst       (RESET),
    .run       ((state == REQ) || (state == XFER)),
    .restart   (wd_restart),
    .expired_c (wd_expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      dir_wr      <= 1'b0;
      pend_valid  <= 1'b0;
      pend_wr     <= 1'b0;
      pend_sector <= 16'h0;
      sd_lba      <= 32'h0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      hdd_mounted <= 1'b0;
      hdd_protect <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
`ifdef HDD_SERVER_TIMEOUT_EN
      wd_restart  <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
`ifdef HDD_SERVER_TIMEOUT_EN
      wd_restart <= 1'b0;
`endif
      if (img_mounted) begin
        hdd_mounted <= (img_size != 64'h0);
        hdd_protect <= img_readonly & (img_size != 64'h0);
      end

      if ((state != IDLE) && in_req) begin
        pend_valid  <= 1'b1;
        pend_wr     <= hdd_write;
        pend_sector <= sector;
      end

      case (state)
        IDLE: begin
          if (take) begin
            pend_valid <= 1'b0;
            if (allowed) begin
              dir_wr <= sel_wr;
              sd_lba <= LBA_BASE + {16'h0, sel_sector};
              sd_rd  <= ~sel_wr;
              sd_wr  <= sel_wr;
              busy   <= 1'b1;
              state  <= REQ;
`ifdef HDD_SERVER_TIMEOUT_EN
              wd_restart <= 1'b1;
`endif
            end
          end
        end
        REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
`ifdef HDD_SERVER_TIMEOUT_EN
            wd_restart <= 1'b1;
`endif
          end
        end
        XFER: begin
          if (!sd_ack) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

`ifdef HDD_SERVER_TIMEOUT_EN
      // abort wins over any same-cycle handshake; pending slot survives
      if (wd_expired) begin
        sd_rd <= 1'b0;
        sd_wr <= 1'b0;
        busy  <= 1'b0;
        err   <= 1'b1;
        state <= IDLE;
      end
`endif
    end
  end

  // buffer port follows the host combinationally while streaming
  always_comb begin
    ram_addr    = '0;
    ram_di      = 8'h0;
    ram_we      = 1'b0;
    sd_buff_din = 8'h0;
    if (state == XFER) begin
      ram_addr = sd_buff_addr;
      if (dir_wr) begin
        sd_buff_din = ram_do;
      end else begin
        ram_di = sd_buff_dout;
        ram_we = sd_buff_wr & sd_ack;
      end
    end
  end
endmodule

// File: tb/tb_hdd_sector_server.sv
// Directed self-checking bench for hdd_sector_server with a sector-buffer model.
module tb_hdd_sector_server;
  logic        clk = 1'b0;
  logic        rst;
  logic        hdd_read, hdd_write;
  logic [15:0] sector;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_di;
  logic        ram_we;
  logic [7:0]  ram_do;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic        hdd_mounted, hdd_protect, busy, err;

  logic [7:0]  mem [512];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hdd_sector_server #(.LBA_BASE(32'h0), .TIMEOUT_CYCLES(100)) dut (
    .CLK_14M(clk), .RESET(rst),
    .hdd_read(hdd_read), .hdd_write(hdd_write), .sector(sector),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
    .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
    .busy(busy), .err(err)
  );

  // card sector buffer: registered read port
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mount(input logic [63:0] size, input logic ro);
    img_size = size; img_readonly = ro; img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [15:0] sec);
    hdd_read = rd; hdd_write = wr; sector = sec;
    tick();
    hdd_read = 1'b0; hdd_write = 1'b0;
  endtask

  task automatic finish_xfer();
    sd_ack = 1'b1; tick();
    sd_ack = 1'b0; tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int good;
    rst = 1'b1; hdd_read = 0; hdd_write = 0; sector = 0; sd_ack = 0;
    sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
    img_mounted = 0; img_size = 0; img_readonly = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mounted", 32'(hdd_mounted), 0);
    chk("rst_lba", sd_lba, 0);
    rst = 1'b0;
    tick();

    mount(64'h200000, 1'b0);
    chk("mount_mounted", 32'(hdd_mounted), 1);
    chk("mount_protect", 32'(hdd_protect), 0);

    // read of sector 0x12, host streams index&0xFF
    req(1, 0, 16'h0012);
    chk("rd_sd_rd", 32'(sd_rd), 1);
    chk("rd_lba", sd_lba, 32'h12);
    chk("rd_busy", 32'(busy), 1);
    tick();
    chk("rd_sd_rd_hold", 32'(sd_rd), 1);
    sd_ack = 1'b1;
    tick();
    chk("rd_ack_drop", 32'(sd_rd), 0);
    good = 0;
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i); sd_buff_dout = 8'(i); sd_buff_wr = 1'b1;
      #1;
      if (ram_we && ram_addr == 9'(i) && ram_di == 8'(i)) good++;
      tick();
    end
    sd_buff_wr = 1'b0;
    chk("rd_beats", 32'(good), 512);
    good = 0;
    for (int i = 0; i < 512; i++) if (mem[i] == 8'(i)) good++;
    chk("rd_mem", 32'(good), 512);
    sd_ack = 1'b0;
    tick();
    chk("rd_done_busy", 32'(busy), 1);
    tick();
    chk("rd_idle_busy", 32'(busy), 0);

    // host strobes in IDLE are ignored
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    #1;
    chk("idle_we", 32'(ram_we), 0);
    tick();
    chk("idle_busy", 32'(busy), 0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;

    // write of sector 5 from the buffer filled above
    req(0, 1, 16'd5);
    chk("wr_sd_wr", 32'(sd_wr), 1);
    chk("wr_sd_rd", 32'(sd_rd), 0);
    chk("wr_lba", sd_lba, 32'd5);
    sd_ack = 1'b1;
    tick();
    chk("wr_ack_drop", 32'(sd_wr), 0);
    good = 0;
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      tick();
      if (sd_buff_din == 8'(i) && !ram_we) good++;
    end
    chk("wr_beats", 32'(good), 512);
    sd_ack = 1'b0;
    tick(); tick();
    chk("wr_idle_busy", 32'(busy), 0);

    // read-only image blocks writes
    mount(64'h200000, 1'b1);
    chk("ro_protect", 32'(hdd_protect), 1);
    req(0, 1, 16'd2);
    chk("ro_sd_wr", 32'(sd_wr), 0);
    chk("ro_busy", 32'(busy), 0);

    // empty image: unmounted, no protect, reads dropped
    mount(64'h0, 1'b1);
    chk("empty_mounted", 32'(hdd_mounted), 0);
    chk("empty_protect", 32'(hdd_protect), 0);
    req(1, 0, 16'd4);
    chk("empty_sd_rd", 32'(sd_rd), 0);
    chk("empty_busy", 32'(busy), 0);

    // pending slot: last request wins, issued at k+3
    mount(64'h200000, 1'b0);
    req(1, 0, 16'd7);
    chk("pend_lba1", sd_lba, 32'd7);
    req(1, 0, 16'd8);
    req(1, 0, 16'd9);
    sd_ack = 1'b1; tick();
    sd_ack = 1'b0; tick();
    chk("pend_done_busy", 32'(busy), 1);
    tick();
    chk("pend_idle_busy", 32'(busy), 0);
    tick();
    chk("pend_sd_rd", 32'(sd_rd), 1);
    chk("pend_lba2", sd_lba, 32'd9);
    finish_xfer();
    chk("pend_end_busy", 32'(busy), 0);

    // simultaneous read and write: write taken
    req(1, 1, 16'h33);
    chk("both_sd_wr", 32'(sd_wr), 1);
    chk("both_sd_rd", 32'(sd_rd), 0);
    chk("both_lba", sd_lba, 32'h33);
    finish_xfer();
    chk("both_end_busy", 32'(busy), 0);

    // reset in mid-XFER
    req(1, 0, 16'd1);
    sd_ack = 1'b1; tick();
    sd_buff_addr = 9'd3; sd_buff_dout = 8'hA5; sd_buff_wr = 1'b1;
    #1;
    chk("mid_we", 32'(ram_we), 1);
    rst = 1'b1;
    #1;
    chk("rstx_we", 32'(ram_we), 0);
    chk("rstx_addr", 32'(ram_addr), 0);
    chk("rstx_di", 32'(ram_di), 0);
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_lba", sd_lba, 0);
    chk("rstx_mounted", 32'(hdd_mounted), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_we", 32'(ram_we), 0);
    chk("post_rst_busy", 32'(busy), 0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();

    mount(64'h200000, 1'b0);
    req(1, 0, 16'd6);
`ifdef HDD_SERVER_TIMEOUT_EN
    repeat (99) tick();
    chk("to_err_early", 32'(err), 0);
    chk("to_sd_rd_early", 32'(sd_rd), 1);
    tick();
    chk("to_err", 32'(err), 1);
    chk("to_sd_rd", 32'(sd_rd), 0);
    chk("to_busy", 32'(busy), 0);
    tick();
    chk("to_err_pulse", 32'(err), 0);
`else
    repeat (150) tick();
    chk("nto_sd_rd", 32'(sd_rd), 1);
    chk("nto_err", 32'(err), 0);
    chk("nto_busy", 32'(busy), 1);
    finish_xfer();
    chk("nto_end_busy", 32'(busy), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
